if_fetch_stage: RTL

- PC register plus IF/ID pipeline register. Sits directly upstream of the load-use hazard detector.
- Consumes the detector's PC_Write and IF_ID_write stall controls and the ID-stage branch redirect.
- Produces the IF/ID instruction fields (Rs/Rt) that the detector compares.
- Talks to instruction memory through a req/valid handshake with wait states, so a redirect can arrive while a fetch is still outstanding.

---
 rtl/if_fetch_stage.sv | 91 +++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register and IF/ID pipeline register with a req/valid imem interface
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   PC_Write, IF_ID_write         stall controls from the hazard detector (0 = hold)
//   branch_taken, branch_target   ID-stage redirect; target bits [1:0] forced to 0
//   imem_req, imem_addr           fetch request and address (stable while waiting)
//   imem_rdata, imem_valid        fetch response
//   IF_ID_instr, IF_ID_pc4        registered instruction and its PC+4
//   IF_ID_valid                   1 = real instruction, 0 = bubble
//   IF_ID_Rs_addr, IF_ID_Rt_addr  register fields of IF_ID_instr for hazard compare
module if_fetch_stage #(
    parameter int PC_WIDTH = 32,
    parameter int INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PC_Write,
    input  logic                   IF_ID_write,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_valid,
    output logic [INSTR_WIDTH-1:0] IF_ID_instr,
    output logic [PC_WIDTH-1:0]    IF_ID_pc4,
    output logic                   IF_ID_valid,
    output logic [4:0]             IF_ID_Rs_addr,
    output logic [4:0]             IF_ID_Rt_addr
);
    typedef enum logic {FETCH, DISCARD} state_t;
    state_t state;
    logic [PC_WIDTH-1:0] pc, pc4, held_addr, saved_target, target;
    logic redirect, req;
    assign redirect = branch_taken & PC_Write;
    assign target = branch_target & ~PC_WIDTH'(3);
    assign pc4 = pc + PC_WIDTH'(4);
    assign imem_req = req;
    // DISCARD keeps presenting the address of the abandoned fetch until its response drains
    assign imem_addr = (state == DISCARD) ? held_addr : pc;
    assign IF_ID_Rs_addr = IF_ID_instr[25:21];
    assign IF_ID_Rt_addr = IF_ID_instr[20:16];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc <= RESET_PC;
            held_addr <= '0;
            saved_target <= '0;
            req <= 1'b0;
            IF_ID_instr <= '0;
            IF_ID_pc4 <= '0;
            IF_ID_valid <= 1'b0;
        end else begin
            req <= 1'b1;
            if (state == FETCH) begin
                if (redirect) begin
                    IF_ID_instr <= '0;
                    IF_ID_valid <= 1'b0;
                    if (imem_valid) begin
                        pc <= target;
                    end else begin
                        // a fetch is outstanding: wait for it to drain before redirecting
                        held_addr <= pc;
                        saved_target <= target;
                        state <= DISCARD;
                    end
                end else if (imem_valid && PC_Write && IF_ID_write) begin
                    IF_ID_instr <= imem_rdata;
                    IF_ID_pc4 <= pc4;
                    IF_ID_valid <= 1'b1;
                    pc <= pc4;
                end else if (IF_ID_write) begin
                    IF_ID_instr <= '0;
                    IF_ID_valid <= 1'b0;
                end
            end else begin
                if (IF_ID_write) begin
                    IF_ID_instr <= '0;
                    IF_ID_valid <= 1'b0;
                end
                if (redirect) saved_target <= target;
                if (imem_valid) begin
                    pc <= redirect ? target : saved_target;
                    state <= FETCH;
                end
            end
        end
    end
endmodule
